add_12_rr_sched: RTL and testbench

- Round-robin scheduler that shares one add_12 pipelined adder among NUM_REQ requesters.
- Each requester offers an operand pair with a valid/ready handshake. At most one pair is issued per cycle.
- Each issue is tagged with the requester ID. The tag travels in a shift pipeline matched to the adder latency, so each sum returns to the requester that issued it.
- Sits between the neural-processor accumulation front-ends and the shared fixed-point adder.

---
 rtl/add_pkg.sv | 23 ++
 rtl/add_12.sv | 38 +++
 rtl/add_12_rr_sched.sv | 144 ++++++++++++++
 tb/tb_add_12_rr_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared constants and helpers for the add_12 adder and its round-robin front-end.
package add_pkg;

   // Latency of add_12 from operand sample to sum visible, and its data width.
   localparam int unsigned ADD12_LAT = 5;
   localparam int unsigned ADD12_W   = 12;

   // Ceiling log2, used to size requester IDs.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = 1; v < n; v = v << 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Width of a packed {valid, id} result tag.
   function automatic int unsigned tag_w(input int unsigned id_w);
      return id_w + 1;
   endfunction

endpackage

// File: rtl/add_12.sv
// Pipelined 12-bit fixed-point adder: sums the upper bytes, low nibble forced to zero.
module add_12
   import add_pkg::*;
#(
   parameter int unsigned LAT = ADD12_LAT
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [ADD12_W-1:0] data_1_i,
   input  logic [ADD12_W-1:0] data_2_i,
   output logic [ADD12_W-1:0] data_sum_o
);

   logic [7:0]         w_sum_hi;
   logic               w_unused_lo;
   logic [ADD12_W-1:0] r_pipe [LAT];

   // Carry out of the upper byte is dropped; fractional nibbles never contribute.
   assign w_sum_hi    = data_1_i[11:4] + data_2_i[11:4];
   assign w_unused_lo = ^{data_1_i[3:0], data_2_i[3:0]};

   // Sum register followed by delay stages to reach the fixed latency.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= {w_sum_hi, 4'h0};
         for (int unsigned i = 1; i < LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign data_sum_o = r_pipe[LAT-1];

endmodule

// File: rtl/add_12_rr_sched.sv
// Round-robin scheduler sharing one add_12 among NUM_REQ requesters; each sum is
// routed back to its issuer by a tag chain aligned with the adder pipeline.
module add_12_rr_sched
   import add_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = clog2(NUM_REQ),
   parameter int unsigned ADD_LAT = ADD12_LAT
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic [NUM_REQ*ADD12_W-1:0] req_data_1_i,
   input  logic [NUM_REQ*ADD12_W-1:0] req_data_2_i,
   input  logic [NUM_REQ-1:0]         en_mask_i,
   output logic [NUM_REQ-1:0]         res_valid_o,
   output logic [ADD12_W-1:0]         res_data_o,
   output logic [ID_W-1:0]            res_id_o,
   output logic [2:0]                 inflight_o,
   output logic                       busy_o
);

   localparam int unsigned TAG_W = tag_w(ID_W);

   logic [ID_W-1:0]    r_ptr;
   logic [TAG_W-1:0]   r_tag [ADD_LAT];
   logic [2:0]         r_inflight;

   logic [NUM_REQ-1:0] w_elig;
   logic [NUM_REQ-1:0] w_gnt;
   logic [ID_W-1:0]    w_gnt_idx;
   logic               w_hs;
   logic [ADD12_W-1:0] w_op1;
   logic [ADD12_W-1:0] w_op2;
   logic [ADD12_W-1:0] w_sum;
   logic               w_last_v;
   logic [ID_W-1:0]    w_last_id;
   logic [NUM_REQ-1:0] w_res_valid;

   assign w_elig = req_valid_i & en_mask_i;

   // Priority search upward from the rr pointer, wrapping at NUM_REQ-1.
   always_comb begin
      int unsigned idx;
      logic [ID_W-1:0] l_idx;
      logic found;
      w_gnt     = '0;
      w_gnt_idx = '0;
      found     = 1'b0;
      idx       = 0;
      l_idx     = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = 32'(r_ptr) + off;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         l_idx = ID_W'(idx);
         if (!found && w_elig[l_idx]) begin
            found        = 1'b1;
            w_gnt[l_idx] = 1'b1;
            w_gnt_idx    = l_idx;
         end
      end
      if (!rst_n_i) begin
         w_gnt = '0;
         found = 1'b0;
      end
      w_hs = found;
   end

   // Operand mux: one-hot grant selects a slice, zero when nothing is granted.
   always_comb begin
      w_op1 = '0;
      w_op2 = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_op1 = req_data_1_i[i*ADD12_W +: ADD12_W];
            w_op2 = req_data_2_i[i*ADD12_W +: ADD12_W];
         end
      end
   end

   add_12 #(
      .LAT (ADD_LAT)
   ) u_add_12 (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .data_1_i   (w_op1),
      .data_2_i   (w_op2),
      .data_sum_o (w_sum)
   );

   // Round-robin pointer advances past the winner on every handshake.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_ptr <= '0;
      end else if (w_hs) begin
         r_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
      end
   end

   // Tag chain: stage 0 is loaded on the same edge that add_12 samples operands.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < ADD_LAT; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_tag[0] <= {w_hs, (w_hs ? w_gnt_idx : '0)};
         for (int unsigned i = 1; i < ADD_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   assign w_last_v  = r_tag[ADD_LAT-1][TAG_W-1];
   assign w_last_id = r_tag[ADD_LAT-1][ID_W-1:0];

   // In-flight count: +1 on issue, -1 as a valid tag leaves the last stage.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_inflight <= '0;
      end else begin
         r_inflight <= r_inflight + {2'b00, w_hs} - {2'b00, w_last_v};
      end
   end

   // One-hot result strobe decoded from the last tag stage.
   always_comb begin
      w_res_valid = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_res_valid[i] = w_last_v && (w_last_id == ID_W'(i));
      end
   end

   assign req_ready_o = w_gnt;
   assign res_valid_o = w_res_valid;
   assign res_id_o    = w_last_id;
   assign res_data_o  = w_sum;
   assign inflight_o  = r_inflight;
   assign busy_o      = |r_inflight;

endmodule

// File: tb/tb_add_12_rr_sched.sv
// Directed self-checking bench for add_12_rr_sched (4 requesters, latency 5).
module tb_add_12_rr_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  valid;
   logic [3:0]  ready;
   logic [47:0] d1;
   logic [47:0] d2;
   logic [3:0]  mask;
   logic [3:0]  res_valid;
   logic [11:0] res_data;
   logic [1:0]  res_id;
   logic [2:0]  inflight;
   logic        busy;

   int errors = 0;
   int checks = 0;

   // Per-requester operands used by the multi-requester scenarios and their sums.
   logic [11:0] fa [4] = '{12'h10F, 12'h20F, 12'h30F, 12'h40F};
   logic [11:0] fb [4] = '{12'h010, 12'h010, 12'h010, 12'h010};
   logic [11:0] fs [4] = '{12'h110, 12'h210, 12'h310, 12'h410};

   always #5 clk = ~clk;

   add_12_rr_sched #(
      .NUM_REQ (4),
      .ID_W    (2),
      .ADD_LAT (5)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_valid_i  (valid),
      .req_ready_o  (ready),
      .req_data_1_i (d1),
      .req_data_2_i (d2),
      .en_mask_i    (mask),
      .res_valid_o  (res_valid),
      .res_data_o   (res_data),
      .res_id_o     (res_id),
      .inflight_o   (inflight),
      .busy_o       (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [11:0] a, input logic [11:0] b);
      d1[i*12 +: 12] = a;
      d2[i*12 +: 12] = b;
   endtask

   task automatic load_table();
      for (int i = 0; i < 4; i++) set_ops(i, fa[i], fb[i]);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid = 4'hF;
      mask  = 4'hF;
      load_table();
      repeat (3) tick();
      #1;
      checks++;
      if (ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready: got %b want %b", ready, 4'b0000);
      end
      tick();
      rst_n = 1'b1;
      valid = 4'h0;
      #1;
      checks++;
      if (res_valid !== 4'b0000) begin
         errors++;
         $display("FAIL reset_res_valid: got %b want %b", res_valid, 4'b0000);
      end
      checks++;
      if (res_data !== 12'h000) begin
         errors++;
         $display("FAIL reset_res_data: got %h want %h", res_data, 12'h000);
      end
      checks++;
      if (res_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_res_id: got %0d want 0", res_id);
      end
      checks++;
      if (inflight !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_inflight: got %0d/%b want 0/0", inflight, busy);
      end
   endtask

   task automatic test_single();
      logic [3:0] exp_v;
      logic [2:0] exp_inf;
      tick();
      set_ops(0, 12'h120, 12'h345);
      valid = 4'b0001;
      #1;
      checks++;
      if (ready !== 4'b0001) begin
         errors++;
         $display("FAIL single_ready: got %b want %b", ready, 4'b0001);
      end
      for (int k = 1; k <= 6; k++) begin
         tick();
         valid = 4'b0000;
         #1;
         exp_v   = (k == 5) ? 4'b0001 : 4'b0000;
         exp_inf = (k <= 5) ? 3'd1 : 3'd0;
         checks++;
         if (res_valid !== exp_v) begin
            errors++;
            $display("FAIL single_res_valid c%0d: got %b want %b", k, res_valid, exp_v);
         end
         checks++;
         if (inflight !== exp_inf || busy !== (exp_inf != 3'd0)) begin
            errors++;
            $display("FAIL single_inflight c%0d: got %0d/%b want %0d", k, inflight, busy, exp_inf);
         end
         if (k == 5) begin
            checks++;
            if (res_id !== 2'd0 || res_data !== 12'h460) begin
               errors++;
               $display("FAIL single_result: got id %0d data %h want id 0 data 460", res_id, res_data);
            end
         end
      end
   endtask

   task automatic test_overflow();
      tick();
      set_ops(3, 12'hFF0, 12'h02F);
      valid = 4'b1000;
      #1;
      checks++;
      if (ready !== 4'b1000) begin
         errors++;
         $display("FAIL overflow_ready: got %b want %b", ready, 4'b1000);
      end
      for (int k = 1; k <= 5; k++) begin
         tick();
         valid = 4'b0000;
         #1;
         if (k == 5) begin
            checks++;
            if (res_valid !== 4'b1000 || res_id !== 2'd3 || res_data !== 12'h010) begin
               errors++;
               $display("FAIL overflow_result: got v %b id %0d data %h want v 1000 id 3 data 010",
                        res_valid, res_id, res_data);
            end
         end
      end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_g;
      logic [3:0] exp_v;
      int issued;
      int retired;
      load_table();
      for (int k = 0; k <= 13; k++) begin
         tick();
         valid = (k < 8) ? 4'hF : 4'h0;
         #1;
         if (k < 8) begin
            exp_g = 4'b0001 << (k % 4);
            checks++;
            if (ready !== exp_g) begin
               errors++;
               $display("FAIL fair_grant c%0d: got %b want %b", k, ready, exp_g);
            end
         end
         exp_v = (k >= 5 && k <= 12) ? (4'b0001 << ((k - 5) % 4)) : 4'b0000;
         checks++;
         if (res_valid !== exp_v) begin
            errors++;
            $display("FAIL fair_res_valid c%0d: got %b want %b", k, res_valid, exp_v);
         end
         if (exp_v != 4'b0000) begin
            checks++;
            if (res_id !== 2'((k - 5) % 4) || res_data !== fs[(k - 5) % 4]) begin
               errors++;
               $display("FAIL fair_result c%0d: got id %0d data %h want id %0d data %h",
                        k, res_id, res_data, (k - 5) % 4, fs[(k - 5) % 4]);
            end
         end
         issued  = (k < 8) ? k : 8;
         retired = (k <= 5) ? 0 : ((k - 5 > 8) ? 8 : k - 5);
         checks++;
         if (inflight !== 3'(issued - retired)) begin
            errors++;
            $display("FAIL fair_inflight c%0d: got %0d want %0d", k, inflight, issued - retired);
         end
      end
   endtask

   task automatic test_mask();
      int g [6] = '{1, 3, 1, 3, 3, 3};
      logic [3:0] exp_g;
      logic [3:0] exp_v;
      load_table();
      for (int k = 0; k <= 11; k++) begin
         tick();
         valid = (k < 6) ? 4'hF : 4'h0;
         mask  = (k < 4) ? 4'b1010 : 4'b1000;
         #1;
         if (k < 6) begin
            exp_g = 4'b0001 << g[k];
            checks++;
            if (ready !== exp_g) begin
               errors++;
               $display("FAIL mask_grant c%0d: got %b want %b", k, ready, exp_g);
            end
         end
         exp_v = (k >= 5 && k <= 10) ? (4'b0001 << g[k - 5]) : 4'b0000;
         checks++;
         if (res_valid !== exp_v) begin
            errors++;
            $display("FAIL mask_res_valid c%0d: got %b want %b", k, res_valid, exp_v);
         end
         if (exp_v != 4'b0000) begin
            checks++;
            if (res_id !== 2'(g[k - 5]) || res_data !== fs[g[k - 5]]) begin
               errors++;
               $display("FAIL mask_result c%0d: got id %0d data %h want id %0d data %h",
                        k, res_id, res_data, g[k - 5], fs[g[k - 5]]);
            end
         end
      end
      mask = 4'hF;
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp_g;
      for (int k = 0; k < 3; k++) begin
         tick();
         valid = 4'hF;
         #1;
         exp_g = 4'b0001 << k;
         checks++;
         if (ready !== exp_g) begin
            errors++;
            $display("FAIL rmid_grant c%0d: got %b want %b", k, ready, exp_g);
         end
      end
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready !== 4'b0000) begin
         errors++;
         $display("FAIL rmid_ready_in_reset: got %b want %b", ready, 4'b0000);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         rst_n = 1'b1;
         valid = 4'h0;
         #1;
         checks++;
         if (res_valid !== 4'b0000 || inflight !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_quiet c%0d: got v %b inflight %0d busy %b want 0000 0 0",
                     k, res_valid, inflight, busy);
         end
      end
      tick();
      valid = 4'hF;
      #1;
      checks++;
      if (ready !== 4'b0001) begin
         errors++;
         $display("FAIL rmid_ptr_restart: got %b want %b", ready, 4'b0001);
      end
      repeat (7) begin
         tick();
         valid = 4'h0;
      end
   endtask

   task automatic test_sparse();
      logic [11:0] sa [3] = '{12'h050, 12'h7F3, 12'hAB0};
      logic [11:0] sb [3] = '{12'h0A5, 12'h81C, 12'h111};
      logic [11:0] ss [3] = '{12'h0F0, 12'h000, 12'hBC0};
      logic [3:0]  exp_g;
      logic [3:0]  exp_v;
      for (int k = 0; k <= 12; k++) begin
         tick();
         if (k % 3 == 0 && k <= 6) begin
            set_ops(2, sa[k / 3], sb[k / 3]);
            valid = 4'b0100;
         end else begin
            valid = 4'b0000;
         end
         #1;
         exp_g = valid;
         checks++;
         if (ready !== exp_g) begin
            errors++;
            $display("FAIL sparse_grant c%0d: got %b want %b", k, ready, exp_g);
         end
         exp_v = (k == 5 || k == 8 || k == 11) ? 4'b0100 : 4'b0000;
         checks++;
         if (res_valid !== exp_v) begin
            errors++;
            $display("FAIL sparse_res_valid c%0d: got %b want %b", k, res_valid, exp_v);
         end
         if (exp_v != 4'b0000) begin
            checks++;
            if (res_id !== 2'd2 || res_data !== ss[(k - 5) / 3]) begin
               errors++;
               $display("FAIL sparse_result c%0d: got id %0d data %h want id 2 data %h",
                        k, res_id, res_data, ss[(k - 5) / 3]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 4'h0;
      mask  = 4'hF;
      d1    = '0;
      d2    = '0;
      test_reset();
      test_single();
      test_overflow();
      test_fairness();
      test_mask();
      test_reset_mid();
      test_sparse();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
